// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one operand bit per clock, LSB first, through a single carry flop.
// Optional signed-overflow flag output vf_o is enabled by defining ALU_OVERFLOW_EN.
module bit_serial_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zf_o,
    output logic             cf_o,
    output logic             sf_o
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             vf_o
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [2:0] OpClr  = 3'b000;
    localparam logic [2:0] OpXor  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b010;
    localparam logic [2:0] OpNand = 3'b011;
    localparam logic [2:0] OpAdd  = 3'b100;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zf_q, zf_d, cf_q, cf_d, sf_q, sf_d;
`ifdef ALU_OVERFLOW_EN
    logic             vf_q, vf_d;
`endif

    logic             a_bit, b_bit, y_bit, s_bit, carry_out, is_arith;
    logic [WIDTH-1:0] shift_next;

    // Single-bit datapath; SUB is a + ~b + 1 with the +1 coming from the carry init.
    always_comb begin
        a_bit      = opa_q[cnt_q];
        b_bit      = opb_q[cnt_q];
        y_bit      = (op_q == OpSub) ? ~b_bit : b_bit;
        is_arith   = (op_q == OpAdd) || (op_q == OpSub);
        carry_out  = (a_bit & y_bit) | (a_bit & carry_q) | (y_bit & carry_q);
        case (op_q)
            OpAdd, OpSub: s_bit = a_bit ^ y_bit ^ carry_q;
            OpXor:        s_bit = a_bit ^ b_bit;
            OpNand:       s_bit = ~(a_bit & b_bit);
            default:      s_bit = 1'b0;
        endcase
        shift_next = {s_bit, shift_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        shift_d  = shift_q;
        carry_d  = carry_q;
        result_d = result_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        sf_d     = sf_q;
`ifdef ALU_OVERFLOW_EN
        vf_d     = vf_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (opcode_i == OpXor || opcode_i == OpSub ||
                        opcode_i == OpNand || opcode_i == OpAdd) begin
                        op_d    = opcode_i;
                        opa_d   = a_i;
                        opb_d   = b_i;
                        cnt_d   = '0;
                        carry_d = (opcode_i == OpSub);
                        state_d = StRun;
                    end else if (opcode_i == OpClr) begin
                        result_d = '0;
                        zf_d     = 1'b0;
                        cf_d     = 1'b0;
                        sf_d     = 1'b0;
`ifdef ALU_OVERFLOW_EN
                        vf_d     = 1'b0;
`endif
                    end
                end
            end
            StRun: begin
                shift_d = shift_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (is_arith) carry_d = carry_out;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = StDone;
                    result_d = shift_next;
                    zf_d     = (shift_next == '0);
                    sf_d     = shift_next[WIDTH-1];
                    // SUB reports borrow, i.e. the inverse of the adder carry.
                    cf_d     = is_arith & (carry_out ^ (op_q == OpSub));
`ifdef ALU_OVERFLOW_EN
                    vf_d     = is_arith & (carry_q ^ carry_out);
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= OpClr;
            opa_q    <= '0;
            opb_q    <= '0;
            shift_q  <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            sf_q     <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            vf_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            shift_q  <= shift_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            sf_q     <= sf_d;
`ifdef ALU_OVERFLOW_EN
            vf_q     <= vf_d;
`endif
        end
    end

    assign busy_o   = (state_q == StRun);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;
    assign zf_o     = zf_q;
    assign cf_o     = cf_q;
    assign sf_o     = sf_q;
`ifdef ALU_OVERFLOW_EN
    assign vf_o     = vf_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu: directed and random ops against an arithmetic model,
// plus WIDTH=4 and WIDTH=16 instances for latency checks. Honours ALU_OVERFLOW_EN.
module tb_bit_serial_alu;

    localparam int W = 8;
    localparam logic [2:0] OP_CLR = 3'b000, OP_XOR = 3'b001, OP_SUB = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011, OP_ADD = 3'b100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [2:0]   opcode = 3'b000;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, zf, cf, sf, vf;
    logic [W-1:0] result;

    logic         start_w = 1'b0;
    logic [3:0]   a4 = '0, b4 = '0, result4;
    logic [15:0]  a16 = '0, b16 = '0, result16;
    logic         busy4, done4, zf4, cf4, sf4, vf4;
    logic         busy16, done16, zf16, cf16, sf16, vf16;

    int n_cmp = 0;
    int n_err = 0;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start_i(start), .opcode_i(opcode), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .result_o(result), .zf_o(zf), .cf_o(cf), .sf_o(sf)
`ifdef ALU_OVERFLOW_EN
        , .vf_o(vf)
`endif
    );

    bit_serial_alu #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .start_i(start_w), .opcode_i(OP_ADD), .a_i(a4), .b_i(b4),
        .busy_o(busy4), .done_o(done4), .result_o(result4), .zf_o(zf4), .cf_o(cf4), .sf_o(sf4)
`ifdef ALU_OVERFLOW_EN
        , .vf_o(vf4)
`endif
    );

    bit_serial_alu #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start_i(start_w), .opcode_i(OP_ADD), .a_i(a16), .b_i(b16),
        .busy_o(busy16), .done_o(done16), .result_o(result16), .zf_o(zf16), .cf_o(cf16),
        .sf_o(sf16)
`ifdef ALU_OVERFLOW_EN
        , .vf_o(vf16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [2:0] op, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] res,
                                  output logic c, output logic v);
        logic [63:0] mask, full;
        logic xs, ys, rs;
        mask = (64'd1 << w) - 64'd1;
        full = '0;
        c = 1'b0;
        case (op)
            OP_ADD: begin full = {32'd0, x} + {32'd0, y}; c = full[w]; end
            OP_SUB: begin full = {32'd0, x} - {32'd0, y}; c = (x < y); end
            OP_XOR: full = {32'd0, x ^ y};
            default: full = ~{32'd0, x & y};
        endcase
        res = 32'(full & mask);
        xs = x[w-1];
        ys = y[w-1];
        rs = res[w-1];
        if (op == OP_ADD) v = (xs == ys) && (rs != xs);
        else if (op == OP_SUB) v = (xs != ys) && (rs != xs);
        else v = 1'b0;
    endfunction

    // Runs one op on the 8-bit DUT; inj >= 0 pulses a SUB start at that RUN cycle.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int inj);
        logic [31:0] er;
        logic ec, ev;
        logic [W-1:0] prev;
        int lat;
        model(W, op, 32'(x), 32'(y), er, ec, ev);
        prev   = result;
        start  = 1'b1;
        opcode = op;
        a      = x;
        b      = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        while (!done && lat < W + 4) begin
            check("busy_in_run", 32'(busy), 32'd1);
            check("result_held", 32'(result), 32'(prev));
            start  = (lat == inj);
            opcode = (lat == inj) ? OP_SUB : opcode;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(lat), 32'(W));
        check("busy_at_done", 32'(busy), 32'd0);
        check("result", 32'(result), er);
        check("zf", 32'(zf), 32'(er == 32'd0));
        check("cf", 32'(cf), 32'(ec));
        check("sf", 32'(sf), 32'(er[W-1]));
`ifdef ALU_OVERFLOW_EN
        check("vf", 32'(vf), 32'(ev));
`endif
        @(posedge clk); #1;
        check("done_single", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic run_wide(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] e4, e16;
        logic c4, c16, v4, v16;
        int lat4, lat16;
        model(4, OP_ADD, x & 32'hF, y & 32'hF, e4, c4, v4);
        model(16, OP_ADD, x & 32'hFFFF, y & 32'hFFFF, e16, c16, v16);
        a4 = x[3:0];
        b4 = y[3:0];
        a16 = x[15:0];
        b16 = y[15:0];
        start_w = 1'b1;
        @(posedge clk); #1;
        start_w = 1'b0;
        lat4 = -1;
        lat16 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done4 && lat4 < 0) begin
                lat4 = c;
                check("w4_result", 32'(result4), e4);
                check("w4_cf", 32'(cf4), 32'(c4));
`ifdef ALU_OVERFLOW_EN
                check("w4_vf", 32'(vf4), 32'(v4));
`endif
            end
            if (done16 && lat16 < 0) begin
                lat16 = c;
                check("w16_result", 32'(result16), e16);
                check("w16_cf", 32'(cf16), 32'(c16));
                check("w16_sf", 32'(sf16), 32'(e16[15]));
`ifdef ALU_OVERFLOW_EN
                check("w16_vf", 32'(vf16), 32'(v16));
`endif
            end
        end
        check("w4_latency", 32'(lat4), 32'd4);
        check("w16_latency", 32'(lat16), 32'd16);
    endtask

    initial begin
        int dones;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {29'd0, zf, cf, sf}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(OP_ADD, 8'hFF, 8'h01, -1);
        check("add_ff_01", {24'd0, result}, 32'h00);
        check("add_ff_01_flags", {29'd0, zf, cf, sf}, 32'b110);
        run_op(OP_SUB, 8'h05, 8'h07, -1);
        check("sub_05_07", {24'd0, result}, 32'hFE);
        run_op(OP_SUB, 8'h07, 8'h05, -1);
        check("sub_07_05_cf", 32'(cf), 32'd0);
        run_op(OP_XOR, 8'hA5, 8'h0F, -1);
        check("xor_a5_0f", {24'd0, result}, 32'hAA);
        run_op(OP_NAND, 8'hFF, 8'hFF, -1);
        check("nand_ff_ff_zf", 32'(zf), 32'd1);
        run_op(OP_SUB, 8'h00, 8'h00, -1);
`ifdef ALU_OVERFLOW_EN
        run_op(OP_ADD, 8'h7F, 8'h01, -1);
        check("ovf_add", {30'd0, vf, sf}, 32'b11);
        run_op(OP_SUB, 8'h80, 8'h01, -1);
        check("ovf_sub", {23'd0, vf, result}, 32'h17F);
`endif

        // Random ops
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(1, 4)), W'($urandom), W'($urandom), -1);
        end

        // Start pulse during RUN plus operand changes: single done, original ADD result
        run_op(OP_ADD, 8'h12, 8'h34, 3);
        check("inj_result", {24'd0, result}, 32'h46);
        @(posedge clk); #1;
        check("inj_not_queued", 32'(busy), 32'd0);

        // Illegal opcode ignored
        start = 1'b1;
        opcode = 3'b110;
        @(posedge clk); #1;
        start = 1'b0;
        check("illegal_busy", 32'(busy), 32'd0);
        check("illegal_result", {24'd0, result}, 32'h46);
        @(posedge clk); #1;
        check("illegal_done", 32'(done), 32'd0);

        // Async reset mid-operation
        start = 1'b1;
        opcode = OP_ADD;
        a = 8'h11;
        b = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_result", {24'd0, result}, 32'd0);
        check("arst_flags", {29'd0, zf, cf, sf}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < W + 3; c++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("arst_no_done", 32'(dones), 32'd0);

        // CLR clears flags with no handshake
        run_op(OP_SUB, 8'h05, 8'h07, -1);
        start = 1'b1;
        opcode = OP_CLR;
        @(posedge clk); #1;
        start = 1'b0;
        check("clr_result", {24'd0, result}, 32'd0);
        check("clr_flags", {29'd0, zf, cf, sf}, 32'd0);
`ifdef ALU_OVERFLOW_EN
        check("clr_vf", 32'(vf), 32'd0);
`endif
        check("clr_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("clr_done", 32'(done), 32'd0);

        // Other widths
        run_wide(32'h0000_FFFF, 32'h0000_0001);
        run_wide(32'h0000_7FF7, 32'h0000_0009);
        for (int i = 0; i < 3; i++) run_wide($urandom, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
